// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_OP_W = 4;

    // Codes 0-7 match funct3; the spare top bit lets illegal codes reach the unit.
    typedef enum logic [MD_OP_W-1:0] {
        MD_OP_MUL    = 4'd0,
        MD_OP_MULH   = 4'd1,
        MD_OP_MULHSU = 4'd2,
        MD_OP_MULHU  = 4'd3,
        MD_OP_DIV    = 4'd4,
        MD_OP_DIVU   = 4'd5,
        MD_OP_REM    = 4'd6,
        MD_OP_REMU   = 4'd7
    } md_op_e;

    typedef enum logic [2:0] {
        MD_ST_IDLE,
        MD_ST_CALC,
        MD_ST_FIX,
        MD_ST_SPECIAL,
        MD_ST_DONE
    } md_state_e;

    localparam logic [31:0] MD_UNKNOWN_RESULT = 32'hdeadbeef;

    function automatic logic md_op_known(input logic [MD_OP_W-1:0] op);
        return (op[MD_OP_W-1] == 1'b0);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU});
    endfunction

    function automatic logic md_a_signed(input md_op_e op);
        return (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM});
    endfunction

    function automatic logic md_b_signed(input md_op_e op);
        return (op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM});
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response handshake between the execute stage and the multiply/divide unit.
interface muldiv_if import muldiv_pkg::*; #(
    parameter int unsigned XLEN_P = XLEN
) ();

    logic               in_valid;
    logic               in_ready;
    logic [MD_OP_W-1:0] op;
    logic [XLEN_P-1:0]  a;
    logic [XLEN_P-1:0]  b;
    logic               kill;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN_P-1:0]  result;

    modport master (
        output in_valid, op, a, b, kill, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, a, b, kill, out_ready,
        output in_ready, out_valid, result
    );

endinterface

// File: rtl/muldiv_step.sv
// One radix-2 iteration on {hi, lo}: shift-add multiply or restoring shift-subtract divide.
module muldiv_step import muldiv_pkg::*; #(
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic              div_i,
    input  logic [XLEN_P-1:0] hi_i,
    input  logic [XLEN_P-1:0] lo_i,
    input  logic [XLEN_P-1:0] opd_i,
    output logic [XLEN_P-1:0] hi_o,
    output logic [XLEN_P-1:0] lo_o
);

    logic [XLEN_P:0] sum;
    logic [XLEN_P:0] shifted;
    logic [XLEN_P:0] diff;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
        shifted = {hi_i, lo_i[XLEN_P-1]};
        // Remainder stays below the divisor, so bit XLEN_P of diff is a clean borrow flag.
        diff    = shifted - {1'b0, opd_i};
        if (div_i) begin
            if (!diff[XLEN_P]) begin
                hi_o = diff[XLEN_P-1:0];
                lo_o = {lo_i[XLEN_P-2:0], 1'b1};
            end else begin
                hi_o = shifted[XLEN_P-1:0];
                lo_o = {lo_i[XLEN_P-2:0], 1'b0};
            end
        end else begin
            hi_o = sum[XLEN_P:1];
            lo_o = {sum[0], lo_i[XLEN_P-1:1]};
        end
    end

endmodule

// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, operand sign handling and result selection.
module muldiv import muldiv_pkg::*; #(
    parameter int unsigned XLEN_P = XLEN
) (
    input logic      clk,
    input logic      rst,
    muldiv_if.slave  md
);

    localparam int unsigned CNT_W = $clog2(XLEN_P);

    md_state_e         state_q, state_d;
    md_op_e            op_q, op_d;
    logic [XLEN_P-1:0] a_q, a_d;
    logic [XLEN_P-1:0] hi_q, hi_d;
    logic [XLEN_P-1:0] lo_q, lo_d;
    logic [XLEN_P-1:0] opd_q, opd_d;
    logic [XLEN_P-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_a_q, neg_a_d;
    logic              neg_b_q, neg_b_d;
    logic              bz_q, bz_d;
    logic              out_valid_q, out_valid_d;

    md_op_e            op_in;
    logic              accept;
    logic              in_neg_a;
    logic              in_neg_b;
    logic              in_special;
    logic [XLEN_P-1:0] step_hi;
    logic [XLEN_P-1:0] step_lo;
    logic [XLEN_P-1:0] fix_res;
    logic [XLEN_P-1:0] spec_res;
    logic [2*XLEN_P-1:0] prod;
    logic [XLEN_P-1:0] quo;
    logic [XLEN_P-1:0] rem;

    muldiv_step #(.XLEN_P(XLEN_P)) u_step (
        .div_i (md_is_div(op_q)),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .opd_i (opd_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo)
    );

    always_comb begin
        op_in      = md_op_e'(md.op);
        accept     = (state_q == MD_ST_IDLE) && md.in_valid && !md.kill;
        in_neg_a   = md_a_signed(op_in) && md.a[XLEN_P-1];
        in_neg_b   = md_b_signed(op_in) && md.b[XLEN_P-1];
        in_special = !md_op_known(md.op)
                   || (md_is_div(op_in)
                       && ((md.b == '0)
                           || ((op_in inside {MD_OP_DIV, MD_OP_REM})
                               && (md.a == {1'b1, {(XLEN_P-1){1'b0}}})
                               && (md.b == '1))));
    end

    always_comb begin
        prod = {hi_q, lo_q};
        if (neg_a_q ^ neg_b_q) begin
            prod = -prod;
        end
        quo = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
        rem = neg_a_q ? -hi_q : hi_q;
        case (op_q)
            MD_OP_MUL:                            fix_res = prod[XLEN_P-1:0];
            MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU: fix_res = prod[2*XLEN_P-1:XLEN_P];
            MD_OP_DIV, MD_OP_DIVU:                fix_res = quo;
            default:                              fix_res = rem;
        endcase

        if (!md_op_known(op_q)) begin
            spec_res = XLEN_P'(MD_UNKNOWN_RESULT);
        end else if (bz_q) begin
            spec_res = (op_q inside {MD_OP_DIV, MD_OP_DIVU}) ? '1 : a_q;
        end else begin
            spec_res = (op_q == MD_OP_DIV) ? a_q : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opd_d       = opd_q;
        result_d    = result_q;
        cnt_d       = cnt_q;
        neg_a_d     = neg_a_q;
        neg_b_d     = neg_b_q;
        bz_d        = bz_q;
        out_valid_d = 1'b0;

        case (state_q)
            MD_ST_IDLE: begin
                if (accept) begin
                    op_d    = op_in;
                    a_d     = md.a;
                    neg_a_d = in_neg_a;
                    neg_b_d = in_neg_b;
                    bz_d    = (md.b == '0);
                    hi_d    = '0;
                    lo_d    = in_neg_a ? -md.a : md.a;
                    opd_d   = in_neg_b ? -md.b : md.b;
                    cnt_d   = '0;
                    state_d = in_special ? MD_ST_SPECIAL : MD_ST_CALC;
                end
            end
            MD_ST_CALC: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(XLEN_P - 1)) begin
                    state_d = MD_ST_FIX;
                end
            end
            MD_ST_FIX: begin
                result_d = fix_res;
                state_d  = MD_ST_DONE;
            end
            MD_ST_SPECIAL: begin
                result_d = spec_res;
                state_d  = MD_ST_DONE;
            end
            MD_ST_DONE: begin
                // out_valid is registered one cycle into DONE, so a handshake needs it already high.
                if (out_valid_q && md.out_ready) begin
                    state_d = MD_ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase

        if (md.kill && (state_q != MD_ST_IDLE)) begin
            state_d     = MD_ST_IDLE;
            result_d    = result_q;
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= MD_ST_IDLE;
            op_q        <= MD_OP_MUL;
            a_q         <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opd_q       <= '0;
            result_q    <= '0;
            cnt_q       <= '0;
            neg_a_q     <= 1'b0;
            neg_b_q     <= 1'b0;
            bz_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opd_q       <= opd_d;
            result_q    <= result_d;
            cnt_q       <= cnt_d;
            neg_a_q     <= neg_a_d;
            neg_b_q     <= neg_b_d;
            bz_q        <= bz_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign md.in_ready  = (state_q == MD_ST_IDLE);
    assign md.out_valid = out_valid_q;
    assign md.result    = result_q;

endmodule

// File: tb/tb_muldiv.sv
// Directed self-checking bench for muldiv: results, latency, backpressure, kill and async reset.
module tb_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    muldiv_if #(.XLEN_P(32)) bus ();

    muldiv #(.XLEN_P(32)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        while (!bus.out_valid && n < 80) begin
            tick();
            n++;
        end
        check({tag, " latency"}, n, exp_lat);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, " valid drop"}, bus.out_valid, 1'b0);
        check({tag, " back idle"}, bus.in_ready, 1'b1);
    endtask

    task automatic run(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
        check({tag, " ready"}, bus.in_ready, 1'b1);
        issue(op, a, b);
        check({tag, " busy"}, bus.in_ready, 1'b0);
        wait_valid(tag, lat);
        check({tag, " result"}, bus.result, exp);
        release_result(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int seen;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.kill      = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset out_valid", bus.out_valid, 1'b0);
        check("reset result", bus.result, 32'h0);
        rst = 1'b0;
        tick();

        run("mul 7*-3", MD_OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 34);
        run("mulh min*min", MD_OP_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run("mulhu max*max", MD_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run("mulhsu -1*max", MD_OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run("div -7/2", MD_OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run("rem -7%2", MD_OP_REM, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run("div 100/-7", MD_OP_DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 34);
        run("rem 100%-7", MD_OP_REM, 32'd100, 32'hFFFFFFF9, 32'd2, 34);

        run("div by zero", MD_OP_DIV, 32'd5, 32'd0, 32'hFFFFFFFF, 2);
        run("remu by zero", MD_OP_REMU, 32'd5, 32'd0, 32'd5, 2);
        run("div overflow", MD_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run("rem overflow", MD_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 2);
        run("unknown op", 4'd9, 32'd1, 32'd2, 32'hDEADBEEF, 2);

        // Backpressure on a DIVU result, then a request held across the release.
        issue(MD_OP_DIVU, 32'd100, 32'd7);
        wait_valid("bp divu", 34);
        check("bp divu result", bus.result, 32'd14);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp hold result", bus.result, 32'd14);
            check("bp hold in_ready", bus.in_ready, 1'b0);
            check("bp hold valid", bus.out_valid, 1'b1);
        end
        bus.op        = MD_OP_REMU;
        bus.a         = 32'd100;
        bus.b         = 32'd7;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp release valid", bus.out_valid, 1'b0);
        check("bp release idle", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        check("bp next accepted", bus.in_ready, 1'b0);
        wait_valid("bp remu", 34);
        check("bp remu result", bus.result, 32'd2);
        release_result("bp remu");

        // kill in IDLE blocks acceptance.
        bus.kill = 1'b1;
        issue(MD_OP_MUL, 32'd2, 32'd2);
        bus.kill = 1'b0;
        check("kill idle no accept", bus.in_ready, 1'b1);

        // kill at count 15 of a DIV.
        issue(MD_OP_DIV, 32'd1000, 32'd3);
        repeat (15) tick();
        bus.kill = 1'b1;
        tick();
        bus.kill = 1'b0;
        check("kill calc idle", bus.in_ready, 1'b1);
        check("kill calc valid", bus.out_valid, 1'b0);
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("kill never valid", seen, 0);
        run("mul 3*4", MD_OP_MUL, 32'd3, 32'd4, 32'd12, 34);

        // Asynchronous reset between clock edges mid-CALC.
        issue(MD_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst in_ready", bus.in_ready, 1'b1);
        check("async rst out_valid", bus.out_valid, 1'b0);
        check("async rst result", bus.result, 32'h0);
        #2 rst = 1'b0;
        tick();
        seen = 0;
        repeat (40) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("rst no stale valid", seen, 0);
        run("post rst divu", MD_OP_DIVU, 32'd100, 32'd7, 32'd14, 34);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
